ami_w_arb: RTL
==============

Name: ami_w_arb

Overview:
- Round-robin arbiter that shares one user-side write port of the AXI master write interface among NR requesters.
- Each write burst is granted as a single unit. The requester's AW is forwarded first, then its W beats until wlast, and only then is the port re-arbitrated. This keeps the downstream AW/W ordering intact.
- The requester index is prefixed onto the outgoing ID. B responses are routed back to the issuing requester by that prefix.
- Sits in the usr_clk domain, directly in front of the master's user AW/W/B ports.

Parameters:
NR, 4, number of requesters (2..16)
AXI_DW, 128, data bus width
AXI_AW, 32, address width
AXI_IW, 8, ID width on the master side
AXI_LW, 8, awlen width
AXI_SW, 3, awsize width
RIW, $clog2(NR), derived; requester-index bits carried in the top of the ID
AXI_WSTRBW, AXI_DW/8, derived; strobe width

Ports:
usr_clk  in  1  clock
usr_reset  in  1  asynchronous reset, active-high
req_awid  in  NR x (AXI_IW-RIW)  per-requester ID
req_awaddr/awlen/awsize/awburst  in  NR x AXI_AW/AXI_LW/AXI_SW/2  per-requester AW fields
req_awvalid  in  NR  AW valid
req_awready  out  NR  AW ready
req_wdata/wstrb/wlast  in  NR x AXI_DW/AXI_WSTRBW/1  per-requester W fields
req_wvalid  in  NR  W valid
req_wready  out  NR  W ready
req_wnafull  out  NR  almost-full status, forwarded to the granted requester only
req_bid  out  AXI_IW-RIW  shared B ID
req_bresp  out  2  shared B response
req_bvalid  out  NR  B valid, one-hot
req_bready  in  NR  B ready
usr_awid/awaddr/awlen/awsize/awburst/awvalid  out  -  master-side AW
usr_awready  in  1  master-side AW ready
usr_wdata/wstrb/wlast/wvalid  out  -  master-side W
usr_wready  in  1  master-side W ready
usr_wnafull  in  1  master-side W almost-full status
usr_bid/bresp/bvalid  in  -  master-side B
usr_bready  out  1  master-side B ready
arb_grant  out  NR  one-hot grant; 0 in ARB state
arb_err  out  1  sticky protocol-error flag (see Optional Feature)

Behaviour:
- FSM has three states: ARB, ADDR, DATA. Reset state is ARB.
- ARB:
  - If any req_awvalid is set, choose the winner by round-robin, searching upward from ptr+1 with wrap at NR.
  - Register the winner into gnt, set ptr to the winner index, go to ADDR.
  - Arbitration latency is 1 cycle. No readys are asserted in ARB.
- ADDR:
  - usr_aw* = req_aw*[gnt], with usr_awid = {gnt_idx, req_awid[gnt]}.
  - usr_awvalid = req_awvalid[gnt]; req_awready[gnt] = usr_awready.
  - On the AW handshake, go to DATA.
- DATA:
  - usr_w* = req_w*[gnt]; usr_wvalid = req_wvalid[gnt]; req_wready[gnt] = usr_wready.
  - On a handshake with wlast=1, go to ARB.
  - A W beat that arrives early from the granted requester while in ADDR is not accepted.
- Non-granted requesters always see awready=0, wready=0 and wnafull=0.
- Back-to-back bursts: one idle ARB cycle separates bursts, so the minimum AW-to-AW spacing is 3 cycles for a 1-beat burst.
- B path is fully combinational:
  - Index k = usr_bid[AXI_IW-1 -: RIW]; req_bid = the low ID bits.
  - req_bvalid[k] = usr_bvalid; usr_bready = req_bready[k].
  - If k >= NR, usr_bready = 1, the beat is dropped and arb_err is set.
- B routing is independent of the FSM, so B can complete while another requester holds the grant.
- Reset (asserted at any time, including mid-burst):
  - State returns to ARB, ptr = NR-1 (requester 0 has first priority), gnt = 0, arb_err = 0.
  - usr_awvalid, usr_wvalid and every req_*ready read 0 immediately.
  - A partially transferred burst is abandoned; the master-side FIFOs are reset together with the block.
- A requester dropping awvalid in ADDR before the handshake is illegal. The FSM keeps waiting in ADDR.

Optional Feature:
- Macro: AMI_ARB_CHK_EN.
- Defined:
  - Registered beat counter, cleared on entry to DATA.
  - wlast on any beat other than beat awlen (0-based) sets arb_err.
  - A handshake at beat awlen without wlast sets arb_err. The FSM still waits for wlast.
  - awvalid dropping in ADDR sets arb_err.
  - The out-of-range B index also sets arb_err, as in base behaviour.
- Not defined:
  - No counter logic.
  - arb_err reflects only the out-of-range B index.

Test Plan:
1. Reset, then req0 sends AW (addr 0x1000, len 3) and 4 W beats → usr_awid = {0, id}; exactly 4 W beats forwarded with wlast on beat 3; FSM back in ARB.
2. req0..req3 all present 1-beat bursts continuously → grant order 0,1,2,3,0,…; AW handshakes spaced 3 cycles apart.
3. req2 granted with len 7; req1 asserts awvalid mid-burst → req1_awready stays 0 until req2's wlast, then req1 is granted next.
4. usr_bvalid with usr_bid = {2'd3, 6'h15} → only req_bvalid[3]=1 and req_bid = 0x15; usr_bready follows req_bready[3]; this happens while req0 holds W.
5. Reset asserted at DATA beat 2 of 4 → all valids/readys 0 at once; after release req0 wins first.
6. (AMI_ARB_CHK_EN) len 3 burst with wlast on beat 1 → arb_err=1 and stays set until reset; without the macro, arb_err=0.

Source files
------------

// File: rtl/ami_w_arb_if.sv
// +----------------------------------------------------------------------------+
// | ami_w_arb_if : requester-side and master-side AW/W/B bundle for ami_w_arb  |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface ami_w_arb_if #(
  parameter int NR     = 4,
  parameter int AXI_DW = 128,
  parameter int AXI_AW = 32,
  parameter int AXI_IW = 8,
  parameter int AXI_LW = 8,
  parameter int AXI_SW = 3
);
  localparam int RIW        = $clog2(NR);
  localparam int AXI_WSTRBW = AXI_DW / 8;

  // requester side
  logic [NR-1:0][AXI_IW-RIW-1:0] req_awid;
  logic [NR-1:0][AXI_AW-1:0]     req_awaddr;
  logic [NR-1:0][AXI_LW-1:0]     req_awlen;
  logic [NR-1:0][AXI_SW-1:0]     req_awsize;
  logic [NR-1:0][1:0]            req_awburst;
  logic [NR-1:0]                 req_awvalid;
  logic [NR-1:0]                 req_awready;
  logic [NR-1:0][AXI_DW-1:0]     req_wdata;
  logic [NR-1:0][AXI_WSTRBW-1:0] req_wstrb;
  logic [NR-1:0]                 req_wlast;
  logic [NR-1:0]                 req_wvalid;
  logic [NR-1:0]                 req_wready;
  logic [NR-1:0]                 req_wnafull;
  logic [AXI_IW-RIW-1:0]         req_bid;
  logic [1:0]                    req_bresp;
  logic [NR-1:0]                 req_bvalid;
  logic [NR-1:0]                 req_bready;

  // master side
  logic [AXI_IW-1:0]             usr_awid;
  logic [AXI_AW-1:0]             usr_awaddr;
  logic [AXI_LW-1:0]             usr_awlen;
  logic [AXI_SW-1:0]             usr_awsize;
  logic [1:0]                    usr_awburst;
  logic                          usr_awvalid;
  logic                          usr_awready;
  logic [AXI_DW-1:0]             usr_wdata;
  logic [AXI_WSTRBW-1:0]         usr_wstrb;
  logic                          usr_wlast;
  logic                          usr_wvalid;
  logic                          usr_wready;
  logic                          usr_wnafull;
  logic [AXI_IW-1:0]             usr_bid;
  logic [1:0]                    usr_bresp;
  logic                          usr_bvalid;
  logic                          usr_bready;

  // arbiter view
  modport slave (
    input  req_awid, req_awaddr, req_awlen, req_awsize, req_awburst, req_awvalid,
    output req_awready,
    input  req_wdata, req_wstrb, req_wlast, req_wvalid,
    output req_wready, req_wnafull,
    output req_bid, req_bresp, req_bvalid,
    input  req_bready,
    output usr_awid, usr_awaddr, usr_awlen, usr_awsize, usr_awburst, usr_awvalid,
    input  usr_awready,
    output usr_wdata, usr_wstrb, usr_wlast, usr_wvalid,
    input  usr_wready, usr_wnafull,
    input  usr_bid, usr_bresp, usr_bvalid,
    output usr_bready
  );

  // environment view (requesters plus AXI master)
  modport master (
    output req_awid, req_awaddr, req_awlen, req_awsize, req_awburst, req_awvalid,
    input  req_awready,
    output req_wdata, req_wstrb, req_wlast, req_wvalid,
    input  req_wready, req_wnafull,
    input  req_bid, req_bresp, req_bvalid,
    output req_bready,
    input  usr_awid, usr_awaddr, usr_awlen, usr_awsize, usr_awburst, usr_awvalid,
    output usr_awready,
    input  usr_wdata, usr_wstrb, usr_wlast, usr_wvalid,
    output usr_wready, usr_wnafull,
    output usr_bid, usr_bresp, usr_bvalid,
    input  usr_bready
  );
endinterface

`default_nettype wire

// File: rtl/ami_w_arb.sv
// +----------------------------------------------------------------------------+
// | ami_w_arb : round-robin burst arbiter for the AXI master user write port.  |
// | Optional burst-length checker under `AMI_ARB_CHK_EN.        rev 1.0        |
// +----------------------------------------------------------------------------+
`default_nettype none

module ami_w_arb #(
  parameter int NR     = 4,
  parameter int AXI_DW = 128,
  parameter int AXI_AW = 32,
  parameter int AXI_IW = 8,
  parameter int AXI_LW = 8,
  parameter int AXI_SW = 3
) (
  input  logic          usr_clk,
  input  logic          usr_reset,
  ami_w_arb_if.slave    bus,
  output logic [NR-1:0] arb_grant,
  output logic          arb_err
);
  localparam int RIW = $clog2(NR);

  typedef enum logic [1:0] {
    ST_ARB  = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t        r_state;
  logic [NR-1:0] r_gnt;
  logic [RIW-1:0] r_gnt_idx;
  logic [RIW-1:0] r_ptr;
  logic          r_err;

  logic          w_any;
  logic [RIW-1:0] w_win_idx;
  logic [RIW-1:0] w_cand;
  logic          w_st_addr;
  logic          w_st_data;
  logic          w_aw_hs;
  logic          w_w_hs;
  logic [RIW-1:0] w_b_idx;
  logic          w_b_oor;
  logic          w_b_err;
  logic [NR-1:0] w_bvalid;
  logic          w_bready;
  logic          w_chk_err;

  // Round-robin search starting just above the last winner.
  always_comb begin
    w_any     = 1'b0;
    w_win_idx = '0;
    w_cand    = '0;
    for (int i = 1; i <= NR; i++) begin
      w_cand = RIW'((int'(r_ptr) + i) % NR);
      if (!w_any && bus.req_awvalid[w_cand]) begin
        w_any     = 1'b1;
        w_win_idx = w_cand;
      end
    end
  end

  assign w_st_addr = (r_state == ST_ADDR);
  assign w_st_data = (r_state == ST_DATA);

  assign bus.usr_awid    = {r_gnt_idx, bus.req_awid[r_gnt_idx]};
  assign bus.usr_awaddr  = bus.req_awaddr[r_gnt_idx];
  assign bus.usr_awlen   = bus.req_awlen[r_gnt_idx];
  assign bus.usr_awsize  = bus.req_awsize[r_gnt_idx];
  assign bus.usr_awburst = bus.req_awburst[r_gnt_idx];
  assign bus.usr_awvalid = w_st_addr & bus.req_awvalid[r_gnt_idx];
  assign bus.req_awready = r_gnt & {NR{w_st_addr & bus.usr_awready}};

  assign bus.usr_wdata   = bus.req_wdata[r_gnt_idx];
  assign bus.usr_wstrb   = bus.req_wstrb[r_gnt_idx];
  assign bus.usr_wlast   = bus.req_wlast[r_gnt_idx];
  assign bus.usr_wvalid  = w_st_data & bus.req_wvalid[r_gnt_idx];
  assign bus.req_wready  = r_gnt & {NR{w_st_data & bus.usr_wready}};
  assign bus.req_wnafull = r_gnt & {NR{bus.usr_wnafull}};

  assign w_aw_hs = bus.usr_awvalid & bus.usr_awready;
  assign w_w_hs  = bus.usr_wvalid & bus.usr_wready;

  // B routing is purely combinational and independent of the grant.
  assign w_b_idx = bus.usr_bid[AXI_IW-1 -: RIW];

  generate
    if (NR == (1 << RIW)) begin : g_b_full
      assign w_b_oor = 1'b0;
    end else begin : g_b_part
      assign w_b_oor = (int'(w_b_idx) >= NR);
    end
  endgenerate

  always_comb begin
    w_bvalid = '0;
    w_bready = 1'b1;
    if (!w_b_oor) begin
      w_bvalid[w_b_idx] = bus.usr_bvalid;
      w_bready          = bus.req_bready[w_b_idx];
    end
  end

  assign bus.req_bvalid = w_bvalid;
  assign bus.usr_bready = w_bready;
  assign bus.req_bid    = bus.usr_bid[AXI_IW-RIW-1:0];
  assign bus.req_bresp  = bus.usr_bresp;
  assign w_b_err        = bus.usr_bvalid & w_b_oor;

`ifdef AMI_ARB_CHK_EN
  logic [AXI_LW-1:0] r_beat;
  logic [AXI_LW-1:0] r_len;

  always_ff @(posedge usr_clk or posedge usr_reset) begin
    if (usr_reset) begin
      r_beat <= '0;
      r_len  <= '0;
    end else if (w_aw_hs) begin
      r_beat <= '0;
      r_len  <= bus.usr_awlen;
    end else if (w_w_hs) begin
      r_beat <= r_beat + 1'b1;
    end
  end

  // wlast must coincide exactly with beat awlen; awvalid must hold in ADDR.
  assign w_chk_err = (w_w_hs & (bus.usr_wlast != (r_beat == r_len)))
                   | (w_st_addr & ~bus.req_awvalid[r_gnt_idx]);
`else
  assign w_chk_err = 1'b0;
`endif

  always_ff @(posedge usr_clk or posedge usr_reset) begin
    if (usr_reset) begin
      r_state   <= ST_ARB;
      r_gnt     <= '0;
      r_gnt_idx <= '0;
      r_ptr     <= RIW'(NR - 1);
      r_err     <= 1'b0;
    end else begin
      r_err <= r_err | w_b_err | w_chk_err;
      case (r_state)
        ST_ARB: begin
          if (w_any) begin
            r_gnt     <= {{(NR-1){1'b0}}, 1'b1} << w_win_idx;
            r_gnt_idx <= w_win_idx;
            r_ptr     <= w_win_idx;
            r_state   <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (w_aw_hs) begin
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_w_hs && bus.usr_wlast) begin
            r_state <= ST_ARB;
            r_gnt   <= '0;
          end
        end
        default: begin
          r_state <= ST_ARB;
          r_gnt   <= '0;
        end
      endcase
    end
  end

  assign arb_grant = r_gnt;
  assign arb_err   = r_err;

endmodule

`default_nettype wire
